vs0_wbm_guard: RTL and testbench

Request-buffering and timeout guard between the Virtual Socket 0 (VS0) Wishbone master port and its crossbar master port. It registers VS0's pipelined requests through a two-entry skid buffer and caps the number of outstanding transactions. If the crossbar does not answer within a programmable number of cycles, it aborts the bus cycle and returns an error to VS0 for every pending request. This keeps a misbehaving or unmapped slave from hanging the VS0 master.

---
 rtl/vs0_wbm_guard.sv | 163 ++++++++++++++++
 tb/tb_vs0_wbm_guard.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vs0_wbm_guard.sv
// vs0_wbm_guard: buffers VS0 Wishbone requests through a two-entry skid
// register, caps outstanding requests and aborts stuck bus cycles on timeout.
module vs0_wbm_guard #(
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [27:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic        s_we_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_stb_i,
    input  logic        s_cyc_i,
    output logic        s_stall_o,
    output logic        s_ack_o,
    output logic        s_err_o,
    output logic [27:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic        m_stall_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        timeout_o,
    input  logic        timeout_clr_i
);
    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
    state_t state, state_nxt;

    logic [64:0] in_req, out_req, skid_req;
    logic        out_valid, skid_valid;
    logic [3:0]  outstanding;
    logic [15:0] tmo_cnt;
    logic [4:0]  pend_cnt;

    logic busy, flush, has_outs, accept, issue, resp, out_ready;
    logic tmo_reload, timeout_hit, drop_all;

    assign busy     = (state == BUSY);
    assign flush    = (state == FLUSH);
    assign has_outs = (outstanding != 4'd0);
    assign in_req   = {s_adr_i, s_dat_i, s_we_i, s_sel_i};
    assign {m_adr_o, m_dat_o, m_we_o, m_sel_o} = out_req;

    assign s_stall_o = skid_valid | flush;
    assign accept    = s_cyc_i & s_stb_i & ~s_stall_o;
    assign m_cyc_o   = s_cyc_i & busy;
    assign m_stb_o   = out_valid & (outstanding != MAX_OUT) & busy;
    assign issue     = m_stb_o & ~m_stall_i;
    assign out_ready = ~out_valid | issue;

    // Responses are forwarded only while something is actually in flight
    assign resp    = busy & has_outs & (m_ack_i | m_err_i);
    assign s_ack_o = busy & has_outs & m_ack_i;
    assign s_err_o = (busy & has_outs & m_err_i) | (flush & (pend_cnt != 5'd0));
    assign s_dat_o = busy ? m_dat_i : 32'd0;

    assign tmo_reload  = ~busy | ~has_outs | m_ack_i | m_err_i | issue;
    assign timeout_hit = busy & s_cyc_i & ~tmo_reload & (tmo_cnt == TO_LAST);
    assign drop_all    = (busy & ~s_cyc_i) | timeout_hit | flush;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_cyc_i) state_nxt = BUSY;
            BUSY: begin
                if (!s_cyc_i) begin
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH:   if (pend_cnt <= 5'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The skid entry only fills when the output register cannot move on
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_req    <= '0;
            skid_req   <= '0;
        end else if (drop_all) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_ready) begin
            if (skid_valid) begin
                out_req    <= skid_req;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_req   <= in_req;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_req   <= in_req;
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            outstanding <= 4'd0;
        end else if (~busy | ~s_cyc_i | timeout_hit) begin
            outstanding <= 4'd0;
        end else if (issue & ~resp) begin
            outstanding <= outstanding + 4'd1;
        end else if (resp & ~issue) begin
            outstanding <= outstanding - 4'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 16'd0;
        end else if (tmo_reload) begin
            tmo_cnt <= 16'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // A request accepted in the timeout cycle is already lost downstream, so it is owed an error too
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= 5'd0;
        end else if (timeout_hit) begin
            pend_cnt <= 5'(outstanding) + 5'(out_valid) + 5'(skid_valid) + 5'(accept);
        end else if (flush && pend_cnt != 5'd0) begin
            pend_cnt <= pend_cnt - 5'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            timeout_o <= 1'b0;
        end else if (timeout_hit) begin
            timeout_o <= 1'b1;
        end else if (timeout_clr_i) begin
            timeout_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vs0_wbm_guard.sv
// tb_vs0_wbm_guard: directed scenarios against a transaction-level reference
// model of the guard, compared on every cycle.
module tb_vs0_wbm_guard;
    localparam int TIMEOUT_CYCLES  = 16;
    localparam int MAX_OUTSTANDING = 4;
    localparam logic [27:0] ERR_ADR = 28'h00002A5;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] s_adr_i = '0;
    logic [31:0] s_dat_i = '0;
    logic [31:0] s_dat_o;
    logic        s_we_i = 1'b0;
    logic [3:0]  s_sel_i = '0;
    logic        s_stb_i = 1'b0;
    logic        s_cyc_i = 1'b0;
    logic        s_stall_o, s_ack_o, s_err_o;
    logic [27:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i = '0;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_stb_o, m_cyc_o;
    logic        m_stall_i = 1'b0;
    logic        m_ack_i = 1'b0;
    logic        m_err_i = 1'b0;
    logic        timeout_o;
    logic        timeout_clr_i = 1'b0;

    always #5 sys_clk = ~sys_clk;

    vs0_wbm_guard #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .sys_clk(sys_clk), .rst(rst),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_i(s_we_i),
        .s_sel_i(s_sel_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_stall_o(s_stall_o),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_stall_i(m_stall_i),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check_output(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [27:0] a);
        return {a[3:0], a} ^ 32'h5A5A_0000;
    endfunction

    // Reference model: idle/busy/flush, queue of buffered requests, count in flight
    int          md_state = 0;
    logic [64:0] md_buf[$];
    int          md_outs = 0;
    int          md_last = 0;
    int          md_errs = 0;
    bit          md_to = 1'b0;
    bit          e_busy, e_flush, e_stall, e_stb, e_issue, e_rok, e_acc, e_rsp, e_tmo;
    logic [64:0] e_req;

    // Scenario bookkeeping and the responding slave
    int          ack_cnt, err_cnt, issue_cnt, last_issue, drop_cyc;
    int          stall_run, max_stall_run, err_run, max_err_run;
    bit          prev_cyc = 1'b0;
    logic [31:0] rd_q[$];
    logic [59:0] iss_q[$];
    logic [27:0] slv_adr[$];
    int          slv_due[$];
    bit          slv_hold = 1'b0;
    int          slv_delay = 2;
    bit          drv_abort = 1'b0;
    bit          drv_busy = 1'b0;

    always @(negedge sys_clk) begin
        if (rst) begin
            check_output("rst_m_cyc_o", m_cyc_o, 0);
            check_output("rst_m_stb_o", m_stb_o, 0);
            check_output("rst_m_req", {m_adr_o, m_dat_o, m_we_o, m_sel_o}, 0);
            check_output("rst_s_stall_o", s_stall_o, 0);
            check_output("rst_s_resp", {s_ack_o, s_err_o, s_dat_o}, 0);
            check_output("rst_timeout_o", timeout_o, 0);
            md_state = 0; md_buf.delete(); md_outs = 0; md_errs = 0; md_to = 1'b0;
            prev_cyc = 1'b0; stall_run = 0; err_run = 0;
        end else begin
            e_busy  = (md_state == 1);
            e_flush = (md_state == 2);
            e_stall = e_flush || (md_buf.size() == 2);
            e_stb   = e_busy && (md_buf.size() > 0) && (md_outs < MAX_OUTSTANDING);
            e_issue = e_stb && !m_stall_i;
            e_rok   = e_busy && (md_outs > 0);
            check_output("s_stall_o", s_stall_o, e_stall);
            check_output("m_cyc_o", m_cyc_o, s_cyc_i && e_busy);
            check_output("m_stb_o", m_stb_o, e_stb);
            if (e_stb) check_output("m_req", {m_adr_o, m_dat_o, m_we_o, m_sel_o}, md_buf[0]);
            check_output("s_ack_o", s_ack_o, e_rok && m_ack_i);
            check_output("s_err_o", s_err_o, (e_rok && m_err_i) || (e_flush && md_errs > 0));
            check_output("s_dat_o", s_dat_o, e_busy ? m_dat_i : 32'd0);
            check_output("timeout_o", timeout_o, md_to);

            if (s_ack_o) begin ack_cnt++; rd_q.push_back(s_dat_o); end
            if (s_err_o) begin err_cnt++; err_run++; if (err_run > max_err_run) max_err_run = err_run; end
            else err_run = 0;
            if (s_stall_o) begin stall_run++; if (stall_run > max_stall_run) max_stall_run = stall_run; end
            else stall_run = 0;
            if (m_cyc_o && m_stb_o && !m_stall_i) begin
                issue_cnt++; last_issue = cyc;
                iss_q.push_back({m_adr_o, m_dat_o});
                slv_adr.push_back(m_adr_o); slv_due.push_back(cyc + slv_delay);
            end
            if (prev_cyc && !m_cyc_o) drop_cyc = cyc;
            prev_cyc = m_cyc_o;

            e_acc = s_cyc_i && s_stb_i && !e_stall;
            e_req = {s_adr_i, s_dat_i, s_we_i, s_sel_i};
            e_rsp = e_rok && (m_ack_i || m_err_i);
            e_tmo = e_busy && s_cyc_i && md_outs > 0 && !e_issue && !m_ack_i && !m_err_i
                    && (cyc - md_last >= TIMEOUT_CYCLES);
            case (md_state)
                0: begin
                    if (e_acc) md_buf.push_back(e_req);
                    if (s_cyc_i) md_state = 1;
                end
                1: begin
                    if (!s_cyc_i) begin
                        md_buf.delete(); md_outs = 0; md_state = 0;
                    end else if (e_tmo) begin
                        md_errs = md_outs + md_buf.size() + (e_acc ? 1 : 0);
                        md_buf.delete(); md_outs = 0; md_state = 2; md_to = 1'b1;
                    end else begin
                        if (e_issue) void'(md_buf.pop_front());
                        if (e_acc) md_buf.push_back(e_req);
                        md_outs = md_outs + (e_issue ? 1 : 0) - (e_rsp ? 1 : 0);
                        if (e_issue || e_rsp) md_last = cyc;
                    end
                end
                default: begin
                    if (md_errs > 0) md_errs--;
                    if (md_errs == 0) md_state = 0;
                end
            endcase
            if (timeout_clr_i && !e_tmo) md_to = 1'b0;
        end
        cyc++;
    end

    always @(posedge sys_clk) begin
        #1;
        m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = 32'd0;
        if (!slv_hold && slv_due.size() > 0 && slv_due[0] <= cyc) begin
            if (slv_adr[0] == ERR_ADR) m_err_i = 1'b1;
            else begin m_ack_i = 1'b1; m_dat_i = rd_data(slv_adr[0]); end
            void'(slv_adr.pop_front()); void'(slv_due.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic clear_counts();
        ack_cnt = 0; err_cnt = 0; issue_cnt = 0; last_issue = -1; drop_cyc = -1;
        stall_run = 0; max_stall_run = 0; err_run = 0; max_err_run = 0;
        rd_q.delete(); iss_q.delete();
    endtask

    // Pipelined master: present each request until it is taken
    task automatic apply_stimulus(input int n, input logic [27:0] base, input logic we);
        bit stalled;
        int guard;
        drv_busy = 1'b1;
        for (int i = 0; i < n && !drv_abort; i++) begin
            s_stb_i = 1'b1; s_adr_i = base + 28'(i); s_dat_i = 32'hD000_0000 + i;
            s_we_i = we; s_sel_i = 4'hF ^ 4'(i);
            guard = 0;
            forever begin
                @(negedge sys_clk);
                stalled = s_stall_o;
                @(posedge sys_clk); #1;
                if (!stalled || drv_abort) break;
                guard++;
                if (guard > 200) begin
                    checks++; errors++;
                    $display("[TB] FAIL drv_stall_wait: stalled %0d cycles, limit 200", guard);
                    break;
                end
            end
        end
        s_stb_i = 1'b0;
        drv_busy = 1'b0;
    endtask

    task automatic wait_acks(input int target, input string name);
        int k = 0;
        while (ack_cnt < target && k < 200) begin step(1); k++; end
        check_output({name, "_ack_count"}, ack_cnt, target);
    endtask

    initial begin
        $display("[TB] vs0_wbm_guard bench start");
        clear_counts();
        step(3);
        rst = 1'b0;
        step(2);

        // Streaming: 8 reads, slave acks 2 cycles after issue
        clear_counts(); slv_delay = 2; s_cyc_i = 1'b1;
        apply_stimulus(8, 28'h100, 1'b0);
        wait_acks(8, "stream");
        s_cyc_i = 1'b0; step(2);
        check_output("stream_err_count", err_cnt, 0);
        check_output("stream_stall_run_le1", max_stall_run <= 1, 1);
        for (int i = 0; i < 8; i++)
            check_output("stream_rd_data", (i < rd_q.size()) ? rd_q[i] : 32'hX, rd_data(28'h100 + 28'(i)));

        // Outstanding cap: slave withholds acks
        clear_counts(); slv_hold = 1'b1; s_cyc_i = 1'b1;
        fork apply_stimulus(7, 28'h200, 1'b0); join_none
        step(12);
        check_output("cap_issue_count", issue_cnt, 4);
        check_output("cap_m_stb_o", m_stb_o, 0);
        check_output("cap_s_stall_o", s_stall_o, 1);
        slv_hold = 1'b0;
        wait_acks(7, "cap");
        check_output("cap_drv_done", drv_busy, 0);
        for (int i = 0; i < 7; i++)
            check_output("cap_issue_order", (i < iss_q.size()) ? iss_q[i][59:32] : 28'hX, 28'h200 + 28'(i));
        s_cyc_i = 1'b0; step(2);

        // Downstream stall during a write burst
        clear_counts(); slv_delay = 1; s_cyc_i = 1'b1;
        fork apply_stimulus(6, 28'h300, 1'b1); join_none
        step(2); m_stall_i = 1'b1; step(5); m_stall_i = 1'b0;
        wait_acks(6, "wstall");
        check_output("wstall_issue_count", issue_cnt, 6);
        for (int i = 0; i < 6; i++)
            check_output("wstall_order", (i < iss_q.size()) ? iss_q[i] : 60'hX,
                         {28'h300 + 28'(i), 32'hD000_0000 + 32'(i)});
        s_cyc_i = 1'b0; step(2);

        // Error passthrough
        clear_counts(); s_cyc_i = 1'b1;
        apply_stimulus(1, ERR_ADR, 1'b0);
        for (int k = 0; k < 20 && err_cnt == 0; k++) step(1);
        check_output("errpass_err_count", err_cnt, 1);
        check_output("errpass_ack_count", ack_cnt, 0);
        s_cyc_i = 1'b0; step(2); slv_delay = 2;

        // Timeout: 3 reads never answered
        clear_counts(); slv_hold = 1'b1; s_cyc_i = 1'b1;
        apply_stimulus(3, 28'h700, 1'b0);
        for (int k = 0; k < 60 && err_cnt < 3; k++) step(1);
        step(2);
        check_output("tmo_cyc_drop_delay", drop_cyc - last_issue, 17);
        check_output("tmo_err_count", err_cnt, 3);
        check_output("tmo_err_run", max_err_run, 3);
        check_output("tmo_flag_set", timeout_o, 1);
        s_cyc_i = 1'b0; slv_hold = 1'b0; step(6);
        check_output("tmo_late_ack_dropped", ack_cnt, 0);
        check_output("tmo_flag_sticky", timeout_o, 1);
        timeout_clr_i = 1'b1; step(1); timeout_clr_i = 1'b0;
        check_output("tmo_flag_cleared", timeout_o, 0);

        // Upstream abort with 2 outstanding
        clear_counts(); slv_hold = 1'b1; s_cyc_i = 1'b1;
        apply_stimulus(2, 28'h400, 1'b0);
        for (int k = 0; k < 20 && issue_cnt < 2; k++) step(1);
        s_cyc_i = 1'b0; #1;
        check_output("abort_m_cyc_same_cycle", m_cyc_o, 0);
        slv_adr.delete(); slv_due.delete();
        step(2);
        check_output("abort_no_err", err_cnt, 0);
        clear_counts(); s_cyc_i = 1'b1;
        apply_stimulus(4, 28'h410, 1'b0);
        step(4);
        check_output("abort_outs_cleared", issue_cnt, 4);
        slv_hold = 1'b0;
        wait_acks(4, "abort");
        s_cyc_i = 1'b0; step(2);

        // Reset with a full buffer
        clear_counts(); slv_hold = 1'b1; s_cyc_i = 1'b1;
        fork apply_stimulus(8, 28'h500, 1'b0); join_none
        for (int k = 0; k < 40 && !s_stall_o; k++) step(1);
        check_output("rst_buffer_full", s_stall_o, 1);
        drv_abort = 1'b1; rst = 1'b1; #1;
        check_output("rst_now_m_cyc_stb", {m_cyc_o, m_stb_o}, 0);
        check_output("rst_now_m_req", {m_adr_o, m_dat_o, m_we_o, m_sel_o}, 0);
        check_output("rst_now_s_out", {s_stall_o, s_ack_o, s_err_o, s_dat_o, timeout_o}, 0);
        for (int k = 0; k < 20 && drv_busy; k++) step(1);
        s_cyc_i = 1'b0; slv_adr.delete(); slv_due.delete(); slv_hold = 1'b0; drv_abort = 1'b0;
        step(2); rst = 1'b0; step(1);
        clear_counts(); s_cyc_i = 1'b1;
        apply_stimulus(1, 28'h600, 1'b0);
        wait_acks(1, "post_rst");
        check_output("post_rst_data", (rd_q.size() > 0) ? rd_q[0] : 32'hX, rd_data(28'h600));
        s_cyc_i = 1'b0; step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
